return_address_stack: RTL and testbench

Parametrised hardware return-address stack for the UCCA monitor, the successor to single-entry return-address capture. On every CALL and IRQ entry it pushes the return address driven on `mdb_out`; on every RET/RETI it pops the top entry and compares it with the target actually loaded into PC. Depth, address width and overflow policy are parameters. Sticky overflow, underflow and mismatch flags feed the UCCA violation logic.

---
 rtl/ucca_pkg.sv | 38 +++
 rtl/ras_mem.sv | 37 +++
 rtl/return_address_stack.sv | 183 ++++++++++++++++++
 tb/tb_return_address_stack.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ucca_pkg.sv
// ---------------------------------------------------------------------------
// ucca_pkg
// Shared constants for the UCCA monitor blocks: the core execution-state and
// single-operand decode values that identify CALL / IRQ entry, the operation
// encoding used inside the return-address stack, and the push decode helper.
// ---------------------------------------------------------------------------
package ucca_pkg;

  // Core execution states
  localparam logic [3:0] CALL_STATE = 4'hB;
  localparam logic [3:0] IRQ_STATE  = 4'h1;

  // One-hot single-operand instruction decode
  localparam logic [7:0] CALL_INST  = 8'h20;
  localparam logic [7:0] IRQ_INST   = 8'h80;
  localparam logic [7:0] RETI_INST  = 8'h40;

  // Per-cycle stack operation, encoded as {push, pop}
  typedef enum logic [1:0] {
    RAS_IDLE = 2'b00,
    RAS_POP  = 2'b01,
    RAS_PUSH = 2'b10,
    RAS_SWAP = 2'b11
  } ras_op_e;

  // A push needs an exact match on the one-hot decode; any other inst_so
  // value (including multi-hot garbage) is ignored.
  function automatic logic push_decode(input logic [3:0] e_state,
                                       input logic [7:0] inst_so,
                                       input logic       track_irq);
    logic call_hit;
    logic irq_hit;
    call_hit = (e_state == CALL_STATE) && (inst_so == CALL_INST);
    irq_hit  = track_irq && (e_state == IRQ_STATE) && (inst_so == IRQ_INST);
    return call_hit || irq_hit;
  endfunction

endpackage

// File: rtl/ras_mem.sv
// ---------------------------------------------------------------------------
// ras_mem
// DEPTH x ADDR_W register file backing the return-address stack.
// Storage has no reset: an entry is only ever read after it has been written.
//
// Ports
//   clk      in   core clock
//   we_i     in   write enable
//   waddr_i  in   write index
//   wdata_i  in   write data
//   raddr_i  in   read index (top of stack)
//   rdata_o  out  asynchronous read data
// ---------------------------------------------------------------------------
module ras_mem #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 8,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [PTR_W-1:0]  waddr_i,
  input  logic [ADDR_W-1:0] wdata_i,
  input  logic [PTR_W-1:0]  raddr_i,
  output logic [ADDR_W-1:0] rdata_o
);

  logic [ADDR_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/return_address_stack.sv
// ---------------------------------------------------------------------------
// return_address_stack
// Hardware return-address stack for the UCCA monitor. CALL (and optionally
// IRQ) entry pushes the return address on mdb_out; a RET/RETI pops the top
// entry and compares it against the address actually loaded into PC.
// Overflow, underflow and mismatch are sticky until reset.
//
// Ports
//   clk         in   core clock, rising edge
//   reset       in   synchronous, active-high
//   inst_so     in   one-hot single-operand decode
//   e_state     in   core execution state
//   mdb_out     in   return address to push
//   ret_strobe  in   RET/RETI loading PC this cycle
//   ret_target  in   value loaded into PC (valid with ret_strobe)
//   ret_addr    out  top of stack, 0 when empty
//   count       out  number of valid entries
//   empty/full  out  count==0 / count==DEPTH
//   overflow, underflow, mismatch  out  sticky error flags
//   violation   out  OR of the sticky flags
//
// Strobe semantics: there is no back-pressure. A push (decoded from
// e_state/inst_so) and a pop (ret_strobe) are each single-cycle qualifiers
// that are consumed on the rising edge they are sampled; the stack always
// accepts one push, one pop, or one combined push+pop per cycle.
// ---------------------------------------------------------------------------
module return_address_stack
  import ucca_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DEPTH     = 8,
  parameter int OVF_WRAP  = 0,
  parameter int TRACK_IRQ = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 inst_so,
  input  logic [3:0]                 e_state,
  input  logic [ADDR_W-1:0]          mdb_out,
  input  logic                       ret_strobe,
  input  logic [ADDR_W-1:0]          ret_target,
  output logic [ADDR_W-1:0]          ret_addr,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow,
  output logic                       mismatch,
  output logic                       violation
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // wr_ptr_q is the next free slot; the top lives one slot below it (mod DEPTH).
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              mismatch_q, mismatch_d;

  logic [PTR_W-1:0]  ptr_inc;
  logic [PTR_W-1:0]  top_idx;
  logic              is_empty;
  logic              is_full;
  logic              push;
  logic              pop;
  ras_op_e           op;

  logic              mem_we;
  logic [PTR_W-1:0]  mem_waddr;
  logic [ADDR_W-1:0] mem_rdata;

  // Explicit wrap so non-power-of-two depths stay modulo DEPTH.
  assign ptr_inc = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
  assign top_idx = (wr_ptr_q == '0) ? PTR_W'(DEPTH - 1) : wr_ptr_q - PTR_W'(1);

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_W'(DEPTH));

  assign push = push_decode(e_state, inst_so, TRACK_IRQ != 0);
  assign pop  = ret_strobe;
  assign op   = ras_op_e'({push, pop});

  ras_mem #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mdb_out),
    .raddr_i (top_idx),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    mismatch_d  = mismatch_q;
    mem_we      = 1'b0;
    mem_waddr   = wr_ptr_q;

    // Pop checks always look at the pre-edge top, even when a push
    // replaces that top in the same cycle.
    if (pop) begin
      if (is_empty) begin
        underflow_d = 1'b1;
      end else if (ret_target != mem_rdata) begin
        mismatch_d = 1'b1;
      end
    end

    case (op)
      RAS_SWAP: begin
        if (is_empty) begin
          // Nothing to replace: behaves as a plain push into an empty stack.
          mem_we    = 1'b1;
          mem_waddr = wr_ptr_q;
          wr_ptr_d  = ptr_inc;
          count_d   = CNT_W'(1);
        end else begin
          // Return then call: top is swapped in place, depth unchanged.
          mem_we    = 1'b1;
          mem_waddr = top_idx;
        end
      end
      RAS_PUSH: begin
        if (!is_full) begin
          mem_we    = 1'b1;
          mem_waddr = wr_ptr_q;
          wr_ptr_d  = ptr_inc;
          count_d   = count_q + CNT_W'(1);
        end else begin
          overflow_d = 1'b1;
          if (OVF_WRAP != 0) begin
            // When full the next free slot is also the oldest entry.
            mem_we    = 1'b1;
            mem_waddr = wr_ptr_q;
            wr_ptr_d  = ptr_inc;
          end
        end
      end
      RAS_POP: begin
        if (!is_empty) begin
          wr_ptr_d = top_idx;
          count_d  = count_q - CNT_W'(1);
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      mismatch_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      mismatch_q  <= mismatch_d;
    end
  end

  assign ret_addr  = is_empty ? '0 : mem_rdata;
  assign count     = count_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign mismatch  = mismatch_q;
  assign violation = overflow_q | underflow_q | mismatch_q;

endmodule

// File: tb/tb_return_address_stack.sv
// ---------------------------------------------------------------------------
// tb_return_address_stack
// Two instances share one stimulus stream:
//   dut_a : OVF_WRAP=0, TRACK_IRQ=1
//   dut_b : OVF_WRAP=1, TRACK_IRQ=0
// A queue-based stack model predicts both every cycle; predictions go into
// expected queues and are popped when the outputs are sampled.
// ---------------------------------------------------------------------------
module tb_return_address_stack;

  typedef enum int {OP_NOP, OP_CALL, OP_IRQ, OP_RET, OP_SWAP, OP_BAD, OP_RST, OP_RSTCALL} op_e;
  typedef logic [15:0] aq_t[$];

  typedef struct {
    op_e         op;
    logic [15:0] mdb;
    logic [15:0] tgt;
    logic [15:0] exp_ret;
    logic [3:0]  exp_cnt;
    logic [2:0]  exp_flags;   // {overflow, underflow, mismatch} of dut_a
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [7:0]  inst_so;
  logic [3:0]  e_state;
  logic [15:0] mdb_out;
  logic        ret_strobe;
  logic [15:0] ret_target;

  logic [15:0] ret_a, ret_b;
  logic [3:0]  cnt_a, cnt_b;
  logic        emp_a, full_a, ovf_a, unf_a, mis_a, vio_a;
  logic        emp_b, full_b, ovf_b, unf_b, mis_b, vio_b;

  return_address_stack #(.ADDR_W(16), .DEPTH(8), .OVF_WRAP(0), .TRACK_IRQ(1)) dut_a (
    .clk(clk), .reset(reset), .inst_so(inst_so), .e_state(e_state),
    .mdb_out(mdb_out), .ret_strobe(ret_strobe), .ret_target(ret_target),
    .ret_addr(ret_a), .count(cnt_a), .empty(emp_a), .full(full_a),
    .overflow(ovf_a), .underflow(unf_a), .mismatch(mis_a), .violation(vio_a)
  );

  return_address_stack #(.ADDR_W(16), .DEPTH(8), .OVF_WRAP(1), .TRACK_IRQ(0)) dut_b (
    .clk(clk), .reset(reset), .inst_so(inst_so), .e_state(e_state),
    .mdb_out(mdb_out), .ret_strobe(ret_strobe), .ret_target(ret_target),
    .ret_addr(ret_b), .count(cnt_b), .empty(emp_b), .full(full_b),
    .overflow(ovf_b), .underflow(unf_b), .mismatch(mis_b), .violation(vio_b)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [25:0] exp_a_q[$];
  logic [25:0] exp_b_q[$];
  aq_t         stk_a, stk_b;
  logic [2:0]  fl_a = 3'b000;
  logic [2:0]  fl_b = 3'b000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [25:0] pack_exp(input aq_t q, input logic [2:0] fl);
    logic [15:0] top;
    top = (q.size() > 0) ? q[q.size()-1] : 16'h0000;
    return {top, 4'(q.size()), q.size() == 0, q.size() == 8, fl, |fl};
  endfunction

  // Reference behaviour of one stack instance for one clock edge.
  task automatic model_step(input bit wrap, input bit trk, inout aq_t q, inout logic [2:0] fl,
                            input op_e op, input logic [15:0] mdb, input logic [15:0] tgt);
    bit push, pop;
    push = (op == OP_CALL) || (op == OP_SWAP) || (op == OP_RSTCALL) || ((op == OP_IRQ) && trk);
    pop  = (op == OP_RET) || (op == OP_SWAP);
    if (op == OP_RST || op == OP_RSTCALL) begin
      q.delete();
      fl = 3'b000;
      return;
    end
    if (pop) begin
      if (q.size() == 0) fl[1] = 1'b1;
      else if (q[q.size()-1] != tgt) fl[0] = 1'b1;
    end
    if (push && pop) begin
      if (q.size() > 0) q[q.size()-1] = mdb;
      else q.push_back(mdb);
    end else if (pop) begin
      if (q.size() > 0) void'(q.pop_back());
    end else if (push) begin
      if (q.size() < 8) q.push_back(mdb);
      else begin
        fl[2] = 1'b1;
        if (wrap) begin
          void'(q.pop_front());
          q.push_back(mdb);
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_op(input op_e op, input logic [15:0] mdb, input logic [15:0] tgt);
    logic [25:0] ea, eb;
    @(negedge clk);
    reset      = (op == OP_RST) || (op == OP_RSTCALL);
    e_state    = 4'h0;
    inst_so    = 8'h00;
    ret_strobe = (op == OP_RET) || (op == OP_SWAP);
    mdb_out    = mdb;
    ret_target = tgt;
    case (op)
      OP_CALL, OP_SWAP, OP_RSTCALL: begin e_state = 4'hB; inst_so = 8'h20; end
      OP_IRQ:                       begin e_state = 4'h1; inst_so = 8'h80; end
      OP_BAD:                       begin e_state = 4'hB; inst_so = 8'h40; end
      default: ;
    endcase
    model_step(1'b0, 1'b1, stk_a, fl_a, op, mdb, tgt);
    model_step(1'b1, 1'b0, stk_b, fl_b, op, mdb, tgt);
    exp_a_q.push_back(pack_exp(stk_a, fl_a));
    exp_b_q.push_back(pack_exp(stk_b, fl_b));
    @(posedge clk);
    #1;
    ea = exp_a_q.pop_front();
    eb = exp_b_q.pop_front();
    check("sb_dut_a", 32'({ret_a, cnt_a, emp_a, full_a, ovf_a, unf_a, mis_a, vio_a}), 32'(ea));
    check("sb_dut_b", 32'({ret_b, cnt_b, emp_b, full_b, ovf_b, unf_b, mis_b, vio_b}), 32'(eb));
  endtask

  // ---------------- test ----------------
  vec_t vecs[24];

  initial begin
    reset = 1'b1; inst_so = 8'h00; e_state = 4'h0;
    mdb_out = 16'h0000; ret_strobe = 1'b0; ret_target = 16'h0000;

    vecs[0]  = '{OP_RST,     16'h0000, 16'h0000, 16'h0000, 4'd0, 3'b000};
    vecs[1]  = '{OP_CALL,    16'hE0A4, 16'h0000, 16'hE0A4, 4'd1, 3'b000};
    vecs[2]  = '{OP_RET,     16'h0000, 16'hE0A4, 16'h0000, 4'd0, 3'b000};
    vecs[3]  = '{OP_CALL,    16'h1000, 16'h0000, 16'h1000, 4'd1, 3'b000};
    vecs[4]  = '{OP_CALL,    16'h2000, 16'h0000, 16'h2000, 4'd2, 3'b000};
    vecs[5]  = '{OP_CALL,    16'h3000, 16'h0000, 16'h3000, 4'd3, 3'b000};
    vecs[6]  = '{OP_RET,     16'h0000, 16'h3000, 16'h2000, 4'd2, 3'b000};
    vecs[7]  = '{OP_RET,     16'h0000, 16'h2000, 16'h1000, 4'd1, 3'b000};
    vecs[8]  = '{OP_RET,     16'h0000, 16'h1FFE, 16'h0000, 4'd0, 3'b001};
    vecs[9]  = '{OP_RST,     16'h0000, 16'h0000, 16'h0000, 4'd0, 3'b000};
    vecs[10] = '{OP_RET,     16'h0000, 16'h0000, 16'h0000, 4'd0, 3'b010};
    vecs[11] = '{OP_CALL,    16'h1234, 16'h0000, 16'h1234, 4'd1, 3'b010};
    vecs[12] = '{OP_RET,     16'h0000, 16'h1234, 16'h0000, 4'd0, 3'b010};
    vecs[13] = '{OP_RST,     16'h0000, 16'h0000, 16'h0000, 4'd0, 3'b000};
    vecs[14] = '{OP_IRQ,     16'hF00C, 16'h0000, 16'hF00C, 4'd1, 3'b000};
    vecs[15] = '{OP_BAD,     16'hBEEF, 16'h0000, 16'hF00C, 4'd1, 3'b000};
    vecs[16] = '{OP_RET,     16'h0000, 16'hF00C, 16'h0000, 4'd0, 3'b000};
    vecs[17] = '{OP_CALL,    16'h1111, 16'h0000, 16'h1111, 4'd1, 3'b000};
    vecs[18] = '{OP_CALL,    16'h4444, 16'h0000, 16'h4444, 4'd2, 3'b000};
    vecs[19] = '{OP_SWAP,    16'h5555, 16'h4444, 16'h5555, 4'd2, 3'b000};
    vecs[20] = '{OP_RET,     16'h0000, 16'h5555, 16'h1111, 4'd1, 3'b000};
    vecs[21] = '{OP_RSTCALL, 16'h6666, 16'h0000, 16'h0000, 4'd0, 3'b000};
    vecs[22] = '{OP_SWAP,    16'h7777, 16'h0000, 16'h7777, 4'd1, 3'b010};
    vecs[23] = '{OP_RET,     16'h0000, 16'h7777, 16'h0000, 4'd0, 3'b010};

    for (int i = 0; i < 24; i++) begin
      do_op(vecs[i].op, vecs[i].mdb, vecs[i].tgt);
      check($sformatf("vec%0d", i), 32'({ret_a, cnt_a, ovf_a, unf_a, mis_a}),
            32'({vecs[i].exp_ret, vecs[i].exp_cnt, vecs[i].exp_flags}));
      if (i == 14) check("irq_untracked_cnt", 32'(cnt_b), 32'd0);
      if (i == 8)  check("mismatch_violation", 32'(vio_a), 32'd1);
    end

    // Nine pushes into an eight-deep stack, then eight pops.
    do_op(OP_RST, 16'h0000, 16'h0000);
    for (int i = 1; i <= 9; i++) do_op(OP_CALL, 16'(16'h0100 + i), 16'h0000);
    check("ovf_a_flag", 32'({ovf_a, full_a, cnt_a}), 32'({1'b1, 1'b1, 4'd8}));
    check("ovf_b_flag", 32'({ovf_b, full_b, cnt_b}), 32'({1'b1, 1'b1, 4'd8}));
    for (int k = 0; k < 8; k++) begin
      check($sformatf("drop_top%0d", k), 32'(ret_a), 32'(16'h0100 + 8 - k));
      check($sformatf("wrap_top%0d", k), 32'(ret_b), 32'(16'h0100 + 9 - k));
      do_op(OP_RET, 16'h0000, 16'(16'h0100 + 8 - k));
    end
    check("drop_end", 32'({cnt_a, mis_a, emp_a}), 32'({4'd0, 1'b0, 1'b1}));
    check("wrap_end", 32'({cnt_b, mis_b, emp_b}), 32'({4'd0, 1'b1, 1'b1}));

    // Random back-to-back traffic, targets usually matching the model top.
    do_op(OP_RST, 16'h0000, 16'h0000);
    for (int n = 0; n < 400; n++) begin
      op_e         op;
      logic [15:0] mdb, tgt;
      int          r;
      r   = int'($urandom_range(0, 99));
      op  = (r < 2) ? OP_RST : op_e'($urandom_range(0, 5));
      mdb = 16'($urandom_range(0, 65535));
      tgt = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 3) != 0 && stk_a.size() > 0) tgt = stk_a[stk_a.size()-1];
      do_op(op, mdb, tgt);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
